// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue/decode stage in front of the 8-bit ALU.
// Accepts instruction bytes over valid/ready and keeps a 4 x 8-bit register file.
// Drives the ALU operands and opcode for one cycle per ALU instruction.
// Writes the ALU result and zero flag back at the end of that cycle.
module alu_issue_unit #(
  parameter int               DATA_W        = 8,
  parameter logic [DATA_W-1:0] REG_RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              zero_flag,
  output logic              halted,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_IMM,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_SYS = 3'b111;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] regs [4];
  logic [1:0]        rd_q, rs_q;
  logic [2:0]        op_q;
  logic              accept;

  // Decoded fields of the byte currently offered on instr.
  logic [2:0] in_op;
  logic [1:0] in_rd, in_rs;
  assign in_op = instr[7:5];
  assign in_rd = instr[4:3];
  assign in_rs = instr[2:1];

  assign accept   = instr_valid && instr_ready;
  assign dbg_data = regs[dbg_sel];

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and ALU/handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    instr_ready = 1'b0;
    halted      = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 3'b000;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (in_op == OP_LDI)                               state_d = S_IMM;
          else if (in_op == OP_SYS && instr[2:0] == 3'b001)  state_d = S_HALT;
          else if (in_op != OP_SYS)                          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a   = regs[rd_q];
        alu_b   = regs[rs_q];
        alu_op  = op_q;
        state_d = S_IDLE;
      end
      S_IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch instruction fields when an instruction byte is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 2'd0;
      rs_q <= 2'd0;
      op_q <= 3'd0;
    end else if (state_q == S_IDLE && accept) begin
      rd_q <= in_rd;
      rs_q <= in_rs;
      op_q <= in_op;
    end
  end

  // Register file and zero flag write-back (ALU result in EXEC, immediate in IMM).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is architecturally visible, so it is reset like ordinary flops.
      for (int i = 0; i < 4; i++) regs[i] <= REG_RESET_VAL;
      zero_flag <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        regs[rd_q] <= alu_result;
        zero_flag  <= alu_zero;
      end else if (state_q == S_IMM && accept) begin
        regs[rd_q] <= instr;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a behavioural ALU model.
`timescale 1ns/1ps
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic       zero_flag;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_issue_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .zero_flag(zero_flag),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Behavioural 8-bit ALU: ADD, SUB, AND, OR, NOT, SLT (unsigned).
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = ~alu_a;
      3'b101: alu_result = (alu_a < alu_b) ? 8'h01 : 8'h00;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded), then drop valid.
  task automatic send(input logic [7:0] b);
    int n = 0;
    instr       = b;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $error("FAIL send_timeout: observed=ready_low expected=ready_high byte=%h", b);
    end
    tick();
    instr_valid = 1'b0;
  endtask

  logic [7:0] exp_r0;

  initial begin
    rst = 1'b1; instr = 8'h00; instr_valid = 1'b0; dbg_sel = 2'd0;
    tick(); tick();
    // Reset state
    check("rst_ready", {7'd0, instr_ready}, 8'h01);
    check("rst_halted", {7'd0, halted}, 8'h00);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_op", {5'd0, alu_op}, 8'h00);
    rst = 1'b0;
    tick();
    check_reg(2'd0, 8'h00, "rst_r0");
    check_reg(2'd3, 8'h00, "rst_r3");
    check("rst_zf", {7'd0, zero_flag}, 8'h00);

    // LDI R0,5 ; LDI R1,3
    send(8'hC0);
    check("imm_ready", {7'd0, instr_ready}, 8'h01);
    send(8'h05);
    send(8'hC8);
    send(8'h03);
    check_reg(2'd0, 8'h05, "ldi_r0");
    check_reg(2'd1, 8'h03, "ldi_r1");
    check("ldi_zf", {7'd0, zero_flag}, 8'h00);
    check("ldi_ready", {7'd0, instr_ready}, 8'h01);

    // ADD R0,R1
    send(8'h02);
    check("add_alu_a", alu_a, 8'h05);
    check("add_alu_b", alu_b, 8'h03);
    check("add_alu_op", {5'd0, alu_op}, 8'h00);
    check("add_ready_exec", {7'd0, instr_ready}, 8'h00);
    tick();
    check("add_ready_after", {7'd0, instr_ready}, 8'h01);
    check_reg(2'd0, 8'h08, "add_r0");
    check("add_zf", {7'd0, zero_flag}, 8'h00);

    // Wrap to zero: LDI R2,FF ; LDI R3,01 ; ADD R2,R3
    send(8'hD0); send(8'hFF);
    send(8'hD8); send(8'h01);
    send(8'h16);
    tick();
    check_reg(2'd2, 8'h00, "wrap_r2");
    check("wrap_zf", {7'd0, zero_flag}, 8'h01);

    // SLT R0,R2 with R0=8, R2=0
    send(8'hA4);
    check("slt_alu_op", {5'd0, alu_op}, 8'h05);
    check("slt_alu_a", alu_a, 8'h08);
    tick();
    check_reg(2'd0, 8'h00, "slt_r0");
    check("slt_zf", {7'd0, zero_flag}, 8'h01);

    // LDI and NOP leave zero_flag alone
    send(8'hC0); send(8'h10);
    send(8'hE0);
    check("ldi_nop_zf", {7'd0, zero_flag}, 8'h01);
    check_reg(2'd0, 8'h10, "ldi2_r0");

    // rd==rs: ADD R0,R0 reads the pre-write value twice
    send(8'h00);
    check("self_alu_b", alu_b, 8'h10);
    tick();
    check_reg(2'd0, 8'h20, "self_r0");
    check("self_zf", {7'd0, zero_flag}, 8'h00);

    // Held valid with SUB R0,R1: one accept per two cycles
    exp_r0 = 8'h20;
    instr = 8'h22; instr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        check("stall_ready_exec", {7'd0, instr_ready}, 8'h00);
        check("stall_alu_a", alu_a, exp_r0);
        exp_r0 = exp_r0 - 8'h03;
      end else begin
        check("stall_ready_idle", {7'd0, instr_ready}, 8'h01);
        check_reg(2'd0, exp_r0, "stall_r0");
      end
    end
    instr_valid = 1'b0;
    tick();
    check_reg(2'd0, 8'h17, "stall_final_r0");

    // HALT: further bytes ignored, registers frozen
    send(8'hE1);
    check("halt_halted", {7'd0, halted}, 8'h01);
    check("halt_ready", {7'd0, instr_ready}, 8'h00);
    instr = 8'h02; instr_valid = 1'b1;
    tick(); tick(); tick();
    instr_valid = 1'b0;
    check("halt_stays", {7'd0, halted}, 8'h01);
    check_reg(2'd0, 8'h17, "halt_r0");
    check("halt_alu_op", {5'd0, alu_op}, 8'h00);
    #3;
    rst = 1'b1;
    #1;
    check("halt_rst_halted", {7'd0, halted}, 8'h00);
    check("halt_rst_ready", {7'd0, instr_ready}, 8'h01);
    check_reg(2'd0, 8'h00, "halt_rst_r0");
    tick();
    rst = 1'b0;

    // Async reset mid-IMM: pending immediate discarded
    send(8'hC0);
    #3;
    rst = 1'b1;
    #1;
    check_reg(2'd0, 8'h00, "midimm_r0");
    #1;
    rst = 1'b0;
    send(8'h42);
    check("midimm_ready_exec", {7'd0, instr_ready}, 8'h00);
    check("midimm_alu_op", {5'd0, alu_op}, 8'h02);
    tick();
    check_reg(2'd0, 8'h00, "midimm_and_r0");
    check("midimm_zf", {7'd0, zero_flag}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
